// File: rtl/pwm_sar_adc_ctrl.sv
// Successive-approximation controller: steps a PWM DAC through MSB-first trial codes,
// waits a number of DAC periods for the RC filter, and keeps or clears each bit from the comparator.
module pwm_sar_adc_ctrl #(
  parameter int WIDTH          = 13,
  parameter int SETTLE_PERIODS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             comp_in,
  input  logic             pwm_zero,
  output logic             dac_enable,
  output logic [WIDTH-1:0] dac_duty,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(SETTLE_PERIODS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [IW-1:0]    IDX_MSB  = IW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_MAX  = CW'(SETTLE_PERIODS);
  localparam logic [WIDTH-1:0] DUTY_MSB = WIDTH'(1) << (WIDTH - 1);

  function automatic logic [WIDTH-1:0] bit_mask(input logic [IW-1:0] idx);
    bit_mask = WIDTH'(1) << idx;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc_s;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] duty_dec_s;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             dac_en_q;
  logic             comp_meta_q;
  logic             comp_s_q;

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      comp_meta_q <= 1'b0;
      comp_s_q    <= 1'b0;
    end else begin
      comp_meta_q <= comp_in;
      comp_s_q    <= comp_meta_q;
    end
  end

  // Next-state and datapath logic for the conversion sequence.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    duty_d     = duty_q;
    result_d   = result_q;
    valid_d    = 1'b0;
    cnt_inc_s  = cnt_q + CW'(1);
    // Comparator verdict on the bit under trial; the next trial bit is OR-ed in on the same write.
    duty_dec_s = comp_s_q ? duty_q : (duty_q & ~bit_mask(idx_q));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          duty_d  = DUTY_MSB;
          idx_d   = IDX_MSB;
          cnt_d   = CW'(0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          duty_d  = {WIDTH{1'b0}};
          cnt_d   = CW'(0);
        end else if (pwm_zero) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == CNT_MAX) begin
            state_d = S_DECIDE;
          end else begin
            state_d = S_SETTLE;
          end
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_DECIDE: begin
        if (abort) begin
          state_d = S_IDLE;
          duty_d  = {WIDTH{1'b0}};
          cnt_d   = CW'(0);
        end else if (idx_q == IW'(0)) begin
          state_d  = S_DONE;
          duty_d   = duty_dec_s;
          result_d = duty_dec_s;
          valid_d  = 1'b1;
        end else begin
          state_d = S_SETTLE;
          idx_d   = idx_q - IW'(1);
          duty_d  = duty_dec_s | bit_mask(idx_q - IW'(1));
          cnt_d   = CW'(0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_DECIDE);
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= IDX_MSB;
      cnt_q    <= CW'(0);
      duty_q   <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      dac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      dac_en_q <= 1'b1;
    end
  end

  assign dac_enable = dac_en_q;
  assign dac_duty   = duty_q;
  assign result     = result_q;
  assign valid      = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pwm_sar_adc_ctrl.sv
// Bench for pwm_sar_adc_ctrl at WIDTH=4, SETTLE_PERIODS=2 with a free-running 16-clock DAC model
// and a threshold comparator; expectations come from the binary-search property of a SAR ADC.
module tb_pwm_sar_adc_ctrl;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic         comp_in;
  logic         pwm_zero;
  logic         dac_enable;
  logic [W-1:0] dac_duty;
  logic [W-1:0] result;
  logic         valid;
  logic         busy;

  int n_vec;
  int n_err;
  int mode;   // 0: comparator against threshold, 1: tied high, 2: tied low
  int thr;

  pwm_sar_adc_ctrl #(.WIDTH(W), .SETTLE_PERIODS(S)) dut (
    .clk        (clk),
    .reset_n    (rst_n),
    .start      (start),
    .abort      (abort),
    .comp_in    (comp_in),
    .pwm_zero   (pwm_zero),
    .dac_enable (dac_enable),
    .dac_duty   (dac_duty),
    .result     (result),
    .valid      (valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DAC model: 4-bit counter, zero flag once every 16 clocks while enabled.
  logic [3:0] dac_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dac_cnt <= 4'd0;
    else if (dac_enable) dac_cnt <= dac_cnt + 4'd1;
  end
  assign pwm_zero = dac_enable && (dac_cnt == 4'd0);

  // Comparator model: one clock of delay after the filtered DAC level.
  always @(posedge clk) begin
    if (mode == 1) comp_in <= 1'b1;
    else if (mode == 2) comp_in <= 1'b0;
    else comp_in <= (int'(dac_duty) <= thr);
  end

  typedef struct {
    int               mode;
    int               thr;
    int               exp_res;
    logic [3:0][3:0]  exp_tr;
    bit               inject;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [3:0][3:0] mk_tr(input int a, input int b, input int c, input int d);
    logic [3:0][3:0] t;
    t[0] = 4'(a); t[1] = 4'(b); t[2] = 4'(c); t[3] = 4'(d);
    return t;
  endfunction

  function automatic vec_t mk_vec(input int m, input int t, input int r, input logic [3:0][3:0] tr, input bit inj);
    vec_t v;
    v.mode = m; v.thr = t; v.exp_res = r; v.exp_tr = tr; v.inject = inj;
    return v;
  endfunction

  // Binary search toward input level v: bits above trial k equal v's bits, trial bit set.
  function automatic logic [3:0][3:0] ref_trials(input int v);
    logic [3:0][3:0] t;
    for (int k = 0; k < 4; k++) begin
      t[k] = 4'(((v >> (4 - k)) << (4 - k)) | (1 << (3 - k)));
    end
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic watch_quiet(input int cycles, input int exp_res);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("quiet_after", bad, 0);
    check("result_held", int'(result), exp_res);
  endtask

  task automatic run_conv(input vec_t v);
    int ntr, since, total, nvalid;
    bit done, prev_busy;
    logic [3:0] prev_duty;
    logic [3:0] tr [4];
    mode = v.mode;
    thr  = v.thr;
    repeat (4) @(negedge clk);
    start = 1'b1;
    ntr = 0; since = 0; total = 0; nvalid = 0; done = 1'b0;
    prev_busy = busy; prev_duty = dac_duty;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      since++;
      if (busy && (!prev_busy || dac_duty != prev_duty)) begin
        if (ntr > 0) check_range("bit_latency", since, 17, 33);
        if (ntr < 4) tr[ntr] = dac_duty;
        ntr++;
        since = 0;
      end
      if (valid) begin
        nvalid++;
        check("busy_low_at_valid", int'(busy), 0);
        check("busy_high_before_valid", int'(prev_busy), 1);
        check_range("last_bit_latency", since, 17, 33);
        check("result", int'(result), v.exp_res);
        check_range("total_latency", total, 69, 133);
        done = 1'b1;
        if (v.inject) start = 1'b1;
      end else if (v.inject && busy && (c % 7 == 3)) begin
        start = 1'b1;
      end
      prev_busy = busy;
      prev_duty = dac_duty;
    end
    if (!done) check("valid_timeout", 0, 1);
    check("trial_count", ntr, 4);
    for (int k = 0; k < 4 && k < ntr; k++) check($sformatf("trial%0d", k), int'(tr[k]), int'(v.exp_tr[k]));
    @(negedge clk);
    start = 1'b0;
    check("valid_one_cycle", int'(valid), 0);
    watch_quiet(40, v.exp_res);
  endtask

  task automatic wait_trial(input int code, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && int'(dac_duty) == code) ok = 1'b1;
    end
    if (!ok) check("trial_wait_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    vec_t v;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2; thr = 0;

    vecs[0] = mk_vec(0, 11, 11, mk_tr(8, 12, 10, 11), 1'b0);
    vecs[1] = mk_vec(1, 0, 15, mk_tr(8, 12, 14, 15), 1'b0);
    vecs[2] = mk_vec(2, 0, 0, mk_tr(8, 4, 2, 1), 1'b0);
    vecs[3] = mk_vec(0, 11, 11, mk_tr(8, 12, 10, 11), 1'b1);
    for (int i = 4; i < 10; i++) begin
      int t;
      t = int'($urandom_range(0, 15));
      vecs[i] = mk_vec(0, t, t, ref_trials(t), (i % 2) == 1);
    end

    repeat (3) @(negedge clk);
    check("rst_dac_enable", int'(dac_enable), 0);
    check("rst_dac_duty", int'(dac_duty), 0);
    check("rst_result", int'(result), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("dac_enable_after_release", int'(dac_enable), 1);
    check("busy_after_release", int'(busy), 0);

    for (int i = 0; i < 10; i++) run_conv(vecs[i]);

    // Abort during the third bit; result must keep the last completed value.
    v = mk_vec(0, 11, 11, mk_tr(8, 12, 10, 11), 1'b0);
    run_conv(v);
    @(negedge clk);
    start = 1'b1;
    wait_trial(10, ok);
    repeat (5) @(negedge clk);
    check("busy_before_abort", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_duty", int'(dac_duty), 0);
    check("abort_valid", int'(valid), 0);
    watch_quiet(40, 11);
    run_conv(v);

    // Reset during the second bit.
    @(negedge clk);
    start = 1'b1;
    wait_trial(12, ok);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_dac_enable", int'(dac_enable), 0);
    check("midrst_duty", int'(dac_duty), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("dac_enable_before_edge", int'(dac_enable), 0);
    @(negedge clk);
    check("dac_enable_one_cycle_after", int'(dac_enable), 1);
    check("post_rst_duty", int'(dac_duty), 0);
    watch_quiet(40, 0);
    run_conv(mk_vec(0, 5, 5, ref_trials(5), 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
